// File: rtl/scoreboard_regfile.sv
// Register file with issue/writeback scoreboard and post-reset zero sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks to the read ports.
module scoreboard_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_busy,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_pending,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  pend_q, pend_d;

    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [XLEN-1:0]   mem_wd;
    logic [XLEN-1:0]   mem_q [NREGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mem_we  = 1'b0;
        mem_wa  = cnt_q;
        mem_wd  = '0;
        if (state_q == INIT) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + ONE;
            pend_d = '0;
            if (cnt_q == LAST) state_d = RUN;
        end else begin
            if (wr_en && wr_addr != '0) begin
                mem_we          = 1'b1;
                mem_wa          = wr_addr;
                mem_wd          = wr_data;
                pend_d[wr_addr] = 1'b0;
            end
            // a new producer supersedes the one completing this edge
            if (iss_en && iss_addr != '0) pend_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= ONE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign init_busy = (state_q == INIT);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rpend;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            rdat  = '0;
            rpend = 1'b0;
            if (state_q == RUN && ra != '0) begin
                rdat  = mem_q[ra];
                rpend = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && wr_addr == ra) begin
                    rdat  = wr_data;
                    rpend = iss_en && (iss_addr == ra);
                end
`endif
            end
        end

        assign rd_data[k*XLEN +: XLEN] = rdat;
        assign rd_pending[k]           = rpend;
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: per-cycle model compare plus directed checks.
module tb_scoreboard_regfile;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   init_busy;
    logic [NUM_RD*AW-1:0]   rd_addr = '0;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_pending;
    logic                   wr_en = 1'b0;
    logic [AW-1:0]          wr_addr = '0;
    logic [XLEN-1:0]        wr_data = '0;
    logic                   iss_en = 1'b0;
    logic [AW-1:0]          iss_addr = '0;

    int errors = 0;
    int checks = 0;

    scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: sweep as a countdown of remaining edges, registers as arrays.
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];
    int              m_left = NREGS - 1;

    initial foreach (m_mem[i]) m_mem[i] = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = NREGS - 1;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    end

    task automatic exp_port(input logic [AW-1:0] a,
                            output logic [XLEN-1:0] d, output logic p);
        d = '0;
        p = 1'b0;
        if (m_left == 0 && a != 0) begin
            d = m_mem[a];
            p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == a) begin
                d = wr_data;
                p = iss_en && (iss_addr == a);
            end
`endif
        end
    endtask

    always @(posedge clk) begin
        logic [XLEN-1:0] ed;
        logic            ep;
        #3;
        chk("cmp_busy", init_busy, m_left != 0);
        for (int k = 0; k < NUM_RD; k++) begin
            exp_port(rd_addr[k*AW +: AW], ed, ep);
            chk("cmp_data", rd_data[k*XLEN +: XLEN], ed);
            chk("cmp_pend", rd_pending[k], ep);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep(input string name);
        int edges = 0;
        while (init_busy === 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        chk(name, edges, NREGS - 1);
    endtask

    task automatic all_zero(input string name);
        for (int r = 1; r < NREGS; r++) begin
            rd_addr = {AW'(r), AW'(NREGS - r)};
            #1;
            chk(name, rd_data, '0);
            chk(name, rd_pending, '0);
            tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", init_busy, 1);
        chk("rst_data", rd_data, '0);
        chk("rst_pend", rd_pending, '0);

        rst = 1'b1;
        count_sweep("sweep_len");
        all_zero("swept_zero");

        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        rd_addr = {AW'(5), AW'(5)};
        tick();
        wr_en = 0;
        #1;
        chk("x5_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("x5_p1", rd_data[63:32], 32'hDEADBEEF);

        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        rd_addr = '0;
        tick();
        wr_en = 0;
        #1;
        chk("x0_zero", rd_data, '0);

        iss_en = 1; iss_addr = 7;
        rd_addr = {AW'(0), AW'(7)};
        tick();
        iss_en = 0;
        #1;
        chk("x7_pend", rd_pending, 2'b01);
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
        tick();
        wr_en = 0;
        #1;
        chk("x7_wb_pend", rd_pending, 2'b00);
        chk("x7_wb_data", rd_data[31:0], 32'h55);

        iss_en = 1; iss_addr = 9;
        wr_en = 1; wr_addr = 9; wr_data = 32'hA5;
        rd_addr = {AW'(9), AW'(0)};
        tick();
        iss_en = 0; wr_en = 0;
        #1;
        chk("x9_data", rd_data[63:32], 32'hA5);
        chk("x9_pend", rd_pending, 2'b10);

        rd_addr = {AW'(3), AW'(0)};
        wr_en = 1; wr_addr = 3; wr_data = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_fwd", rd_data[63:32], 32'hCAFE);
`else
        chk("x3_old", rd_data[63:32], 32'h0);
`endif
        chk("x3_pend", rd_pending, 2'b00);
        tick();
        wr_en = 0;
        #1;
        chk("x3_after", rd_data[63:32], 32'hCAFE);

        rd_addr = {AW'(0), AW'(3)};
        wr_en = 1; wr_addr = 3; wr_data = 32'hBEEF;
        iss_en = 1; iss_addr = 3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_fwd_iss", {rd_pending[0], rd_data[31:0]}, {1'b1, 32'hBEEF});
`else
        chk("x3_old_iss", {rd_pending[0], rd_data[31:0]}, {1'b0, 32'hCAFE});
`endif
        tick();
        wr_en = 0; iss_en = 0;
        #1;
        chk("x3_iss_after", {rd_pending[0], rd_data[31:0]}, {1'b1, 32'hBEEF});

        rst = 0;
        tick();
        rst = 1;
        repeat (9) tick();
        chk("mid_busy", init_busy, 1);
        rst = 0;
        wr_en = 1; wr_addr = 4; wr_data = 32'hFFFF;
        iss_en = 1; iss_addr = 4;
        tick();
        chk("mid_rst_busy", init_busy, 1);
        rst = 1;
        count_sweep("resweep_len");
        wr_en = 0; iss_en = 0;
        all_zero("resweep_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
